// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM state type and default geometry for the RAM controller.
package ram_ctrl_pkg;
    typedef enum logic {IDLE, CLEAR} state_e;
    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser for a raw button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);
    logic s1_q, s2_q, s3_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1_q, s2_q, s3_q} <= 3'b000;
        else     {s1_q, s2_q, s3_q} <= {btn_raw, s1_q, s2_q};
    assign pulse = s2_q & ~s3_q;
endmodule

// File: rtl/ram_ctrl_param.sv
// ram_ctrl_param: single-port RAM controller with debounced-edge write/clear buttons,
// auto-increment write pointer and a one-location-per-cycle clear sequence.
module ram_ctrl_param
    import ram_ctrl_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] din,
    input  logic              we_btn,
    input  logic              clr_btn,
    input  logic              auto_inc,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr_out,
    output logic              busy
);
    localparam int DEPTH = 2**ADDR_W;
    logic we_p, clr_p, busy_q, busy_d, mem_we;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, wptr_q, wptr_d, waddr;
    logic [DATA_W-1:0] wdata, dout_q;
    logic [DATA_W-1:0] mem [DEPTH];
    btn_sync_edge u_we  (.clk(clk), .rst(rst), .btn_raw(we_btn),  .pulse(we_p));
    btn_sync_edge u_clr (.clk(clk), .rst(rst), .btn_raw(clr_btn), .pulse(clr_p));
    assign addr_out = auto_inc ? wptr_q : addr_in;
    assign dout     = dout_q;
    assign busy     = busy_q;
    // Clear beats a simultaneous write; button pulses during CLEAR are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        busy_d  = busy_q;
        mem_we  = 1'b0;
        waddr   = addr_out;
        wdata   = din;
        if (state_q == IDLE) begin
            if (clr_p) begin
                state_d = CLEAR;
                cnt_d   = '0;
                wptr_d  = '0;
                busy_d  = 1'b1;
            end else if (we_p) begin
                mem_we = 1'b1;
                wptr_d = auto_inc ? wptr_q + ADDR_W'(1) : wptr_q;
            end
        end else begin
            mem_we = 1'b1;
            waddr  = cnt_q;
            wdata  = CLR_VAL;
            cnt_d  = cnt_q + ADDR_W'(1);
            if (&cnt_q) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            busy_q  <= busy_d;
            dout_q  <= mem[addr_in];
        end
    // Array is deliberately unreset; the read above samples before this write lands.
    always_ff @(posedge clk)
        if (mem_we) mem[waddr] <= wdata;
endmodule

// File: tb/tb_ram_ctrl_param.sv
// tb_ram_ctrl_param: directed scoreboard bench for the default 32x4 and an 8x8 instance.
module tb_ram_ctrl_param;
    logic       clk = 1'b0, rst = 1'b1;
    logic [4:0] addr_in = '0;
    logic [3:0] din = '0;
    logic       we_btn = 1'b0, clr_btn = 1'b0, auto_inc = 1'b0;
    logic [3:0] dout;
    logic [4:0] addr_out;
    logic       busy;
    logic [2:0] addr2 = '0;
    logic [7:0] din2 = '0;
    logic       we2 = 1'b0, clr2 = 1'b0, auto2 = 1'b0;
    logic [7:0] dout2;
    logic [2:0] aout2;
    logic       busy2;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct {int cyc; int kind; logic [7:0] exp; string name;} exp_t;
    exp_t q[$];

    ram_ctrl_param dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .din(din), .we_btn(we_btn),
        .clr_btn(clr_btn), .auto_inc(auto_inc), .dout(dout), .addr_out(addr_out), .busy(busy)
    );
    ram_ctrl_param #(.DATA_W(8), .ADDR_W(3), .CLR_VAL(8'h5A)) dut2 (
        .clk(clk), .rst(rst), .addr_in(addr2), .din(din2), .we_btn(we2),
        .clr_btn(clr2), .auto_inc(auto2), .dout(dout2), .addr_out(aout2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sel(input int k);
        case (k)
            0: sel = {4'h0, dout};
            1: sel = {7'h0, busy};
            2: sel = {3'h0, addr_out};
            3: sel = dout2;
            4: sel = {7'h0, busy2};
            default: sel = {5'h0, aout2};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] act;
            e = q.pop_front();
            act = sel(e.kind);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic expect_at(input int c, input int k, input logic [7:0] v, input string nm);
        exp_t e;
        e = '{c, k, v, nm};
        q.push_back(e);
    endtask
    task automatic press1(input logic [3:0] d);
        din = d; we_btn = 1'b1; tick(2); we_btn = 1'b0; tick(3);
    endtask
    task automatic press2(input logic [7:0] d);
        din2 = d; we2 = 1'b1; tick(2); we2 = 1'b0; tick(3);
    endtask
    task automatic clr1();
        clr_btn = 1'b1; tick(2); clr_btn = 1'b0; tick(3);
    endtask
    task automatic rd1(input logic [4:0] a, input logic [3:0] v, input string nm);
        addr_in = a; expect_at(cyc + 1, 0, {4'h0, v}, $sformatf("%s_rd%0d", nm, a)); tick(1);
    endtask
    task automatic rd2(input logic [2:0] a, input logic [7:0] v, input string nm);
        addr2 = a; expect_at(cyc + 1, 3, v, $sformatf("%s_rd%0d", nm, a)); tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        tick(1);
        expect_at(cyc, 0, 8'h00, "rst_dout");
        expect_at(cyc, 1, 8'h00, "rst_busy");
        expect_at(cyc, 2, 8'h00, "rst_aout");
        expect_at(cyc, 3, 8'h00, "rst_dout2");
        expect_at(cyc, 4, 8'h00, "rst_busy2");
        tick(1);
        rst = 1'b0;
        tick(2);
        // 1: manual write, long press writes once
        addr_in = 5'd4; press1(4'h7);
        addr_in = 5'd3; din = 4'hA; we_btn = 1'b1;
        n = cyc;
        expect_at(n + 4, 0, 8'h0A, "t1_dout_lat");
        expect_at(n + 8, 0, 8'h0A, "t1_once");
        tick(3); din = 4'h5; tick(3); we_btn = 1'b0; tick(3);
        rd1(5'd4, 4'h7, "t1");
        rd1(5'd3, 4'hA, "t1");
        // 2: auto-increment and wrap
        auto_inc = 1'b1;
        expect_at(cyc, 2, 8'd0, "t2_aout0");
        press1(4'h1); press1(4'h2); press1(4'h3);
        expect_at(cyc, 2, 8'd3, "t2_aout3");
        rd1(5'd0, 4'h1, "t2"); rd1(5'd1, 4'h2, "t2"); rd1(5'd2, 4'h3, "t2");
        for (int i = 3; i < 32; i++) press1(4'(i));
        expect_at(cyc, 2, 8'd0, "t2_wrap");
        press1(4'h9);
        rd1(5'd0, 4'h9, "t2"); rd1(5'd31, 4'hF, "t2"); rd1(5'd1, 4'h2, "t2");
        expect_at(cyc, 2, 8'd1, "t2_aout1");
        // 3: clear after fill, write during busy dropped
        for (int i = 0; i < 32; i++) press1(4'hF);
        n = cyc;
        expect_at(n + 2, 1, 8'd0, "t3_busy_pre");
        for (int j = 3; j <= 34; j++) expect_at(n + j, 1, 8'd1, $sformatf("t3_busy%0d", j - 3));
        expect_at(n + 35, 1, 8'd0, "t3_busy_post");
        clr1();
        press1(4'h7);
        tick(26);
        expect_at(cyc, 2, 8'd0, "t3_wptr");
        for (int a = 0; a < 32; a++) rd1(5'(a), 4'h0, "t3");
        // 4: simultaneous we/clr
        press1(4'h3);
        n = cyc;
        expect_at(n + 2, 1, 8'd0, "t4_busy_pre");
        expect_at(n + 3, 1, 8'd1, "t4_busy");
        din = 4'h6; we_btn = 1'b1; clr_btn = 1'b1; tick(2);
        we_btn = 1'b0; clr_btn = 1'b0; tick(40);
        expect_at(cyc, 2, 8'd0, "t4_wptr");
        rd1(5'd0, 4'h0, "t4"); rd1(5'd1, 4'h0, "t4");
        // 5: reset ten cycles into CLEAR
        for (int i = 0; i < 32; i++) press1(4'hF);
        addr_in = 5'd20;
        n = cyc;
        expect_at(n + 12, 0, 8'h0F, "t5_dout_pre");
        expect_at(n + 12, 1, 8'd1, "t5_busy_pre");
        clr1();
        tick(8);
        rst = 1'b1;
        expect_at(cyc, 0, 8'h00, "t5_dout_async");
        expect_at(cyc, 1, 8'd0, "t5_busy_async");
        expect_at(cyc, 2, 8'd0, "t5_wptr_async");
        tick(1);
        rst = 1'b0;
        tick(2);
        for (int a = 0; a < 32; a++) rd1(5'(a), (a < 10) ? 4'h0 : 4'hF, "t5");
        // 6: 8x8 instance with CLR_VAL 5A
        n = cyc;
        expect_at(n + 2, 4, 8'd0, "t6_busy_pre");
        for (int j = 3; j <= 10; j++) expect_at(n + j, 4, 8'd1, $sformatf("t6_busy%0d", j - 3));
        expect_at(n + 11, 4, 8'd0, "t6_busy_post");
        clr2 = 1'b1; tick(2); clr2 = 1'b0; tick(11);
        for (int a = 0; a < 8; a++) rd2(3'(a), 8'h5A, "t6");
        auto2 = 1'b1;
        expect_at(cyc, 5, 8'd0, "t6_aout0");
        for (int i = 0; i < 8; i++) press2(8'h10 + 8'(i));
        expect_at(cyc, 5, 8'd0, "t6_wrap");
        press2(8'hEE);
        rd2(3'd0, 8'hEE, "t6"); rd2(3'd7, 8'h17, "t6"); rd2(3'd1, 8'h11, "t6");
        expect_at(cyc, 5, 8'd1, "t6_aout1");
        tick(3);
        if (q.size() != 0) begin
            $display("FAIL scoreboard: got %0d pending expectations, expected 0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_ctrl_param.md
Name: ram_ctrl_param

Overview:
Parametrised single-port synchronous RAM controller. It is the successor to the fixed 32x4 board RAM and generalises both data width and depth. Raw push-button inputs are synchronised and edge-detected internally, so the RAM runs on the board clock instead of a button clock. Adds an auto-increment write mode and a hardware clear-all sequence. Sits between the switch/button inputs and the LED/display outputs.

Parameters:
DATA_W, 4, data word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W (local, derived)
CLR_VAL, 0, value of width DATA_W written to every location by the clear sequence

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
addr_in  input  ADDR_W  read address (always); write address in manual mode
din  input  DATA_W  write data
we_btn  input  1  raw write button, asynchronous level
clr_btn  input  1  raw clear button, asynchronous level
auto_inc  input  1  0 = manual addressing, 1 = write to internal pointer
dout  output  DATA_W  registered read data of mem[addr_in]
addr_out  output  ADDR_W  effective write address (addr_in in manual mode, wptr in auto mode)
busy  output  1  high while the clear sequence runs

Behaviour:
- Reset (asynchronous, active-high): all flops clear immediately: sync stages, FSM=IDLE, cnt=0, wptr=0, dout=0, busy=0. The memory array is not reset; its contents are undefined until written or cleared.
- Button path, applied to each of we_btn and clr_btn: 2-FF synchroniser (s1, s2), then a delay flop s3; pulse = s2 & ~s3.
  - One pulse per rising edge, regardless of how long the button is held.
  - Button high at edge k -> pulse high for the cycle after edge k+1 -> write/clear-start acts at edge k+2.
- Write (FSM=IDLE, we pulse, no clr pulse):
  - Manual mode: mem[addr_in] <= din.
  - Auto mode: mem[wptr] <= din, and wptr <= wptr+1 mod DEPTH, so DEPTH-1 wraps to 0.
- wptr holds its value when auto_inc toggles; manual writes do not change it.
- Read: dout <= mem[addr_in] on every edge (1-cycle latency).
  - Read and write to the same address on the same edge: read-first, so dout shows the old data and the new data appears one cycle later.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a clr pulse: cnt <= 0, wptr <= 0.
  - In CLEAR, each cycle: mem[cnt] <= CLR_VAL, cnt <= cnt+1.
  - CLEAR -> IDLE on the edge that writes cnt == DEPTH-1.
  - busy is registered: high exactly DEPTH cycles, asserting the cycle after the clr pulse.
- Simultaneous events:
  - we and clr pulses in the same cycle in IDLE: clear wins, the write is dropped.
  - we or clr pulses during CLEAR are dropped (not queued).
- Reset during CLEAR: returns to IDLE at once. Locations already cleared keep CLR_VAL; the rest keep their prior contents.
- addr_out is combinational from auto_inc, addr_in and wptr.

Decomposition:
- Package ram_ctrl_pkg holds:
  - FSM state typedef (IDLE, CLEAR).
  - Default constants DATA_W_DEF=4, ADDR_W_DEF=5.
- Sub-module btn_sync_edge:
  - Ports clk, rst, btn_raw, pulse.
  - 2-FF synchroniser plus rising-edge detector.
  - Instantiated twice (write button, clear button).

Test Plan:
1. Manual write, default params: rst, then auto_inc=0, addr_in=3, din=4'hA, we_btn high for 6 cycles -> mem[3]=A written exactly once at edge k+2; dout=A at edge k+3; mem[4] unchanged.
2. Auto mode: auto_inc=1, presses with din=1, 2, 3 -> mem[0..2]=1,2,3 and addr_out=3. A further 29 presses bring wptr back to 0; press 33 overwrites mem[0].
3. Clear: after filling all locations with 4'hF, pulse clr_btn -> busy high exactly 32 cycles. Sweeping addr_in 0..31 then reads 0 everywhere; a we_btn press during busy leaves no write.
4. Simultaneous: we_btn and clr_btn rise on the same edge -> clear runs, no write occurs, wptr=0.
5. Reset mid-clear: assert rst 10 cycles into CLEAR -> busy=0, dout=0, wptr=0 without waiting for a clock edge. Locations 0..9 = 0; locations 10..31 keep 4'hF.
6. DATA_W=8, ADDR_W=3, CLR_VAL=8'h5A: clear lasts 8 cycles and every location reads 5A; auto mode wraps after 8 writes.
